// File: rtl/mux_pkg.sv
// Shared types and helpers for the 4-channel round-robin mux scheduler.
// The select encoding is inverted relative to the channel index (sel 00 picks d3).
package mux_pkg;

   localparam int NCH = 4;

   typedef logic [1:0] sel_t;

   typedef enum logic {
      S_IDLE,
      S_GRANT
   } state_t;

   function automatic sel_t idx2sel(input logic [1:0] idx);
      return ~idx;
   endfunction

endpackage

// File: rtl/rr_pick4.sv
// Combinational round-robin picker: first set request bit at or after ptr, wrapping 3->0.
// Reusable wherever a 4-way rotating-priority choice is needed.
module rr_pick4 (
   input  logic [3:0] req_i,
   input  logic [1:0] ptr_i,
   output logic       found_o,
   output logic [1:0] idx_o
);

   logic [1:0] cand;

   // Scan from the farthest offset down so the nearest requester to ptr wins.
   always_comb begin
      found_o = 1'b0;
      idx_o   = ptr_i;
      cand    = ptr_i;
      for (int k = 3; k >= 0; k--) begin
         cand = ptr_i + 2'(k);
         if (req_i[cand]) begin
            found_o = 1'b1;
            idx_o   = cand;
         end
      end
   end

endmodule

// File: rtl/mux4_rr_sched.sv
// Round-robin scheduler driving the select of a 4:1 mux with valid/ready flow control.
// Define MUX_SCHED_CNT_EN to build the per-channel accepted-word counters on grant_cnt.
//
//   state   | meaning
//   S_IDLE  | no word presented; arbitrate on any request
//   S_GRANT | word presented, mux_sel frozen until out_ready accepts it
module mux4_rr_sched
   import mux_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [3:0]         req,
   output logic [3:0]         ch_ack,
   output logic [1:0]         mux_sel,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [4*CNT_W-1:0] grant_cnt
);

   state_t     state_q, state_d;
   logic [1:0] grant_q, grant_d;
   logic [1:0] ptr_q, ptr_d;

   logic       xfer;
   logic [3:0] arb_req;
   logic [1:0] arb_ptr;
   logic       arb_found;
   logic [1:0] arb_idx;

   assign xfer = (state_q == S_GRANT) && out_ready;

   // On an accepted word the next winner is chosen in the same edge, with the
   // acked channel masked and the pointer already advanced past it.
   assign arb_req = xfer ? (req & ~(4'b0001 << grant_q)) : req;
   assign arb_ptr = xfer ? (grant_q + 2'd1) : ptr_q;

   rr_pick4 u_pick (
      .req_i   (arb_req),
      .ptr_i   (arb_ptr),
      .found_o (arb_found),
      .idx_o   (arb_idx)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         grant_q <= 2'd0;
         ptr_q   <= 2'd0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         ptr_q   <= ptr_d;
      end
   end

   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      ptr_d   = ptr_q;
      case (state_q)
         S_IDLE: begin
            if (arb_found) begin
               state_d = S_GRANT;
               grant_d = arb_idx;
            end
         end
         S_GRANT: begin
            if (xfer) begin
               ptr_d = grant_q + 2'd1;
               if (arb_found) begin
                  grant_d = arb_idx;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      out_valid = (state_q == S_GRANT);
      mux_sel   = idx2sel(grant_q);
      ch_ack    = xfer ? (4'b0001 << grant_q) : 4'b0000;
   end

`ifdef MUX_SCHED_CNT_EN
   logic [CNT_W-1:0] cnt_q [NCH];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < NCH; i++) cnt_q[i] <= '0;
      end else begin
         for (int i = 0; i < NCH; i++) begin
            if (ch_ack[i]) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
         end
      end
   end

   for (genvar g = 0; g < NCH; g++) begin : g_cnt
      assign grant_cnt[g*CNT_W +: CNT_W] = cnt_q[g];
   end
`else
   assign grant_cnt = '0;
`endif

endmodule

// File: tb/tb_mux4_rr_sched.sv
// Scoreboard bench for mux4_rr_sched: directed stimulus pushes expected (sel, ack) pairs,
// a negedge monitor pops and compares them on every accepted word.
module tb_mux4_rr_sched;

   localparam int CNT_W = 8;

   logic               clk = 1'b0;
   logic               rst;
   logic [3:0]         req;
   logic [3:0]         ch_ack;
   logic [1:0]         mux_sel;
   logic               out_valid;
   logic               out_ready;
   logic [4*CNT_W-1:0] grant_cnt;

   typedef struct packed {
      logic [1:0] sel;
      logic [3:0] ack;
   } exp_t;

   exp_t exp_q[$];
   exp_t exp_e;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   mux4_rr_sched #(.CNT_W(CNT_W)) dut (
      .clk       (clk),
      .rst       (rst),
      .req       (req),
      .ch_ack    (ch_ack),
      .mux_sel   (mux_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .grant_cnt (grant_cnt)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_checks++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, expv);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic [1:0] sel, input logic [3:0] ack);
      exp_t e;
      e.sel = sel;
      e.ack = ack;
      exp_q.push_back(e);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      @(negedge clk);
      check("rst_valid", 32'(out_valid), 32'd0);
      check("rst_sel",   32'(mux_sel),   32'd3);
      check("rst_ack",   32'(ch_ack),    32'd0);
      step();
      rst = 1'b0;
   endtask

   always @(negedge clk) begin
      if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
         if (exp_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL xfer_unexpected: got sel=%b ack=%b expected no transfer", mux_sel, ch_ack);
         end else begin
            exp_e = exp_q.pop_front();
            check("xfer_sel_ack", 32'({mux_sel, ch_ack}), 32'({exp_e.sel, exp_e.ack}));
         end
      end
   end

   initial begin
      rst       = 1'b1;
      req       = 4'h0;
      out_ready = 1'b0;

      // reset with every channel requesting
      req       = 4'hF;
      out_ready = 1'b1;
      do_reset();
      req = 4'h0;

      // single request on ch2, then wrap from ptr=3 with ch3 absent
      req = 4'b0100;
      push(2'b01, 4'b0100);
      step();
      @(negedge clk);
      check("single_valid", 32'(out_valid), 32'd1);
      check("single_sel",   32'(mux_sel),   32'd1);
      step();
      req = 4'b0011;
      push(2'b11, 4'b0001);
      push(2'b10, 4'b0010);
      @(negedge clk);
      check("single_idle", 32'(out_valid), 32'd0);
      step();
      step();
      req = 4'b0010;
      step();
      req = 4'b0000;
      @(negedge clk);
      check("wrap_idle", 32'(out_valid), 32'd0);
      step();

      // all four held: 0,1,2,3,0 back to back
      do_reset();
      req       = 4'hF;
      out_ready = 1'b1;
      push(2'b11, 4'b0001);
      push(2'b10, 4'b0010);
      push(2'b01, 4'b0100);
      push(2'b00, 4'b1000);
      push(2'b11, 4'b0001);
      repeat (5) step();
      req = 4'h0;
      step();
      @(negedge clk);
      check("rr_idle", 32'(out_valid), 32'd0);
      check("rr_drained", 32'(exp_q.size()), 32'd0);

      // stall on ch1
      do_reset();
      req       = 4'b0010;
      out_ready = 1'b0;
      step();
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         check("stall_sel",   32'(mux_sel),   32'd2);
         check("stall_valid", 32'(out_valid), 32'd1);
         check("stall_ack",   32'(ch_ack),    32'd0);
         step();
      end
      push(2'b10, 4'b0010);
      out_ready = 1'b1;
      @(negedge clk);
      check("stall_release_ack", 32'(ch_ack), 32'b0010);
      step();
      req = 4'b0000;
      @(negedge clk);
      check("stall_idle", 32'(out_valid), 32'd0);
      step();

      // reset while a word is being accepted: word lost, no ack
      req       = 4'b1000;
      out_ready = 1'b0;
      step();
      @(negedge clk);
      check("mid_sel",   32'(mux_sel),   32'd0);
      check("mid_valid", 32'(out_valid), 32'd1);
      step();
      out_ready = 1'b1;
      rst       = 1'b1;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_ack",   32'(ch_ack),    32'd0);
      check("mid_rst_sel",   32'(mux_sel),   32'd3);
      step();
      rst = 1'b0;
      req = 4'b0000;
      step();

`ifdef MUX_SCHED_CNT_EN
      // 260 acks to ch2 wrap its 8-bit counter to 4
      do_reset();
      for (int i = 0; i < 260; i++) push(2'b01, 4'b0100);
      req       = 4'b0100;
      out_ready = 1'b1;
      for (int i = 0; i < 2000 && exp_q.size() > 0; i++) step();
      req = 4'b0000;
      check("cnt_drained", 32'(exp_q.size()), 32'd0);
      step();
      check("cnt_ch0", 32'(grant_cnt[0*CNT_W +: CNT_W]), 32'd0);
      check("cnt_ch1", 32'(grant_cnt[1*CNT_W +: CNT_W]), 32'd0);
      check("cnt_ch2", 32'(grant_cnt[2*CNT_W +: CNT_W]), 32'd4);
      check("cnt_ch3", 32'(grant_cnt[3*CNT_W +: CNT_W]), 32'd0);
`else
      check("cnt_tied", 32'(grant_cnt), 32'd0);
`endif

      check("final_drained", 32'(exp_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
